button_debounce_pulse: RTL

BUTTON_DEBOUNCE_PULSE -- requirements
Module: button_debounce_pulse

---
 rtl/button_debounce_pulse_if.sv | 22 ++
 rtl/button_debounce_pulse.sv | 119 +++++++++++
 2 files changed

// File: rtl/button_debounce_pulse_if.sv
// Signal bundle between a push-button debouncer and the logic around it.
// The master side drives the raw button level. The slave side returns the debounced level and the edge strobes.
interface button_debounce_pulse_if;
  logic btn_in;
  logic db_level;
  logic press_pulse;
  logic release_pulse;

  modport master (
    output btn_in,
    input  db_level,
    input  press_pulse,
    input  release_pulse
  );

  modport slave (
    input  btn_in,
    output db_level,
    output press_pulse,
    output release_pulse
  );
endinterface

// File: rtl/button_debounce_pulse.sv
// Push-button debouncer. It synchronizes the raw level, then qualifies each level change over STABLE_CYCLES samples.
// It produces a registered debounced level plus one-cycle press and release strobes.
module button_debounce_pulse #(
  parameter int STABLE_CYCLES = 1000000,
  parameter int CNT_WIDTH     = 20
) (
  input  logic                    clk,
  input  logic                    reset_n,
  button_debounce_pulse_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    PRESSED,
    WAIT_RELEASE
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 w_in_sync;
  state_t               r_state;
  state_t               w_state_next;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_next;
  logic                 r_db_level;
  logic                 r_press;
  logic                 r_release;
  logic                 w_db_next;
  logic                 w_press_next;
  logic                 w_release_next;

  // Only the synchronizer touches the raw asynchronous button level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= bus.btn_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_in_sync = r_sync2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_db_level <= 1'b0;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_db_level <= w_db_next;
      r_press    <= w_press_next;
      r_release  <= w_release_next;
    end
  end

  // The counter stops at CNT_LAST because reaching it always leaves the wait state.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_press_next   = 1'b0;
    w_release_next = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_in_sync) begin
          w_state_next = WAIT_PRESS;
          w_cnt_next   = '0;
        end
      end
      WAIT_PRESS: begin
        if (!w_in_sync) begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = PRESSED;
          w_cnt_next   = '0;
          w_press_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!w_in_sync) begin
          w_state_next = WAIT_RELEASE;
          w_cnt_next   = '0;
        end
      end
      WAIT_RELEASE: begin
        if (w_in_sync) begin
          w_state_next = PRESSED;
          w_cnt_next   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next   = IDLE;
          w_cnt_next     = '0;
          w_release_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
    w_db_next = (w_state_next == PRESSED) || (w_state_next == WAIT_RELEASE);
  end

  assign bus.db_level      = r_db_level;
  assign bus.press_pulse   = r_press;
  assign bus.release_pulse = r_release;

endmodule
